// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operation sequencer.
//   - ALU opcode constants driven onto ALU_SEL
//   - seq_state_t: sequencer FSM states
//   - alu_cmd_t: command payload accepted on the cmd_* channel
//   - width constants for operands, results and the settle counter
package alu_seq_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 5;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_OP_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_OP_XOR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              chain;
  } alu_cmd_t;

endpackage

// File: rtl/alu_seq_settle_cnt.sv
// alu_seq_settle_cnt: loadable down-counter timing the wait for the datapath
// Result to settle.
//   CLK      in   clock
//   Reset    in   asynchronous active-low reset
//   load     in   load load_val this edge (takes priority over en)
//   load_val in   settle cycle count, 1..15
//   en       in   decrement this edge (stops at zero)
//   last_c   out  combinational strobe: count is 1, this is the final edge
module alu_seq_settle_cnt
  import alu_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt;

  // Down-counter; saturates at zero so a stray enable cannot wrap.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU command over valid/ready, sequences the
// operand-select/ALU datapath controls through LOAD/EXEC/SETTLE, samples the
// datapath Result and returns it over a valid/ready response channel.
// Optional feature macro: ALU_SEQ_CHAIN_EN (chains previous result as operand A).
//   CLK, Reset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_a/cmd_b         ALU opcode and operands
//   cmd_chain                  use previous result as A (chain build only)
//   Operand_A/Operand_B        datapath operands
//   Sel_A/Sel_B                datapath mux selects (1 = operand, 0 = Temp)
//   ALU_SEL                    datapath ALU operation
//   Result                     datapath Temp register
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   captured Result
//   busy                       high whenever not IDLE
// Parameter SETTLE_CYCLES: 1..15 cycles waited after the Temp-load edge.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic              cmd_chain,
  output logic [OPND_W-1:0] Operand_A,
  output logic [OPND_W-1:0] Operand_B,
  output logic              Sel_A,
  output logic              Sel_B,
  output logic [OP_W-1:0]   ALU_SEL,
  input  logic [RES_W-1:0]  Result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  seq_state_t state;
  alu_cmd_t   cmd_in;
  logic       cnt_load_c;
  logic       cnt_en_c;
  logic       settle_last_c;

  assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};

`ifdef ALU_SEQ_CHAIN_EN
  logic              chain_q;
  logic [OPND_W-1:0] last_result;
`else
  logic unused_chain;
  assign unused_chain = cmd_in.chain;
`endif

  // Counter is loaded on the Temp-load edge and runs only in SETTLE.
  assign cnt_load_c = (state == ST_EXEC);
  assign cnt_en_c   = (state == ST_SETTLE);

  alu_seq_settle_cnt u_settle_cnt (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (cnt_load_c),
    .load_val (SETTLE_LD),
    .en       (cnt_en_c),
    .last_c   (settle_last_c)
  );

  // Sequencer FSM; the operand/select/opcode registers double as the latched
  // command and are held outside LOAD so the datapath recirculates unchanged.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      Operand_A <= '0;
      Operand_B <= '0;
      Sel_A     <= 1'b1;
      Sel_B     <= 1'b1;
      ALU_SEL   <= ALU_OP_ADD;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q     <= 1'b0;
      last_result <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_LOAD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            Operand_A <= cmd_in.a;
            Operand_B <= cmd_in.b;
            ALU_SEL   <= cmd_in.op;
            Sel_B     <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q   <= cmd_in.chain;
            Sel_A     <= ~cmd_in.chain;
`else
            Sel_A     <= 1'b1;
`endif
          end
        end
        ST_LOAD: begin
          state <= ST_EXEC;
          Sel_A <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
          // Reg_A now holds Temp[3:0]; drive the same value so it stays put.
          if (chain_q) begin
            Operand_A <= last_result;
          end
`endif
        end
        ST_EXEC: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_last_c) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= Result;
`ifdef ALU_SEQ_CHAIN_EN
            last_result <= Result[OPND_W-1:0];
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer. Contains a
// model of the external datapath (Reg_A/Reg_B/Temp) feeding Result, and a
// command-level reference model of the expected sequencer outputs.
// Honours ALU_SEQ_CHAIN_EN when compiled with it.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int S = 1;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic       cmd_chain = 1'b0;
  logic [3:0] Operand_A;
  logic [3:0] Operand_B;
  logic       Sel_A;
  logic       Sel_B;
  logic [2:0] ALU_SEL;
  logic [4:0] Result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_chain (cmd_chain),
    .Operand_A (Operand_A),
    .Operand_B (Operand_B),
    .Sel_A     (Sel_A),
    .Sel_B     (Sel_B),
    .ALU_SEL   (ALU_SEL),
    .Result    (Result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return 5'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath: operand regs, Temp register holding the ALU output.
  logic [3:0] dp_a, dp_b;
  logic [4:0] dp_temp;
  assign Result = dp_temp;
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      dp_a <= 4'd0; dp_b <= 4'd0; dp_temp <= 5'd0;
    end else begin
      dp_a    <= Sel_A ? Operand_A : dp_temp[3:0];
      dp_b    <= Sel_B ? Operand_B : dp_temp[3:0];
      dp_temp <= alu_ref(ALU_SEL, dp_a, dp_b);
    end
  end

  // Command-level model: m_age counts edges since the accepting edge.
  logic       m_busy, m_rsp_valid, m_sel_a, m_chain;
  int         m_age;
  logic [4:0] m_exp, m_rsp_data, m_last;
  logic [3:0] m_opa, m_opb;
  logic [2:0] m_op;
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m_busy <= 1'b0; m_rsp_valid <= 1'b0; m_sel_a <= 1'b1; m_chain <= 1'b0;
      m_age <= 0; m_exp <= 5'd0; m_rsp_data <= 5'd0; m_last <= 5'd0;
      m_opa <= 4'd0; m_opb <= 4'd0; m_op <= 3'd0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1;
        m_age  <= 1;
        m_op   <= cmd_op;
        m_opa  <= cmd_a;
        m_opb  <= cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
        m_chain <= cmd_chain;
        m_sel_a <= !cmd_chain;
        m_exp   <= alu_ref(cmd_op, cmd_chain ? m_last[3:0] : cmd_a, cmd_b);
`else
        m_chain <= 1'b0;
        m_sel_a <= 1'b1;
        m_exp   <= alu_ref(cmd_op, cmd_a, cmd_b);
`endif
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == 1) begin
        m_sel_a <= 1'b1;
        if (m_chain) m_opa <= m_last[3:0];
      end
      if (m_rsp_valid) begin
        if (rsp_ready) begin
          m_busy <= 1'b0; m_rsp_valid <= 1'b0;
        end
      end else if (m_age == 2 + S) begin
        m_rsp_valid <= 1'b1; m_rsp_data <= m_exp; m_last <= m_exp;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(posedge CLK) begin
    #1;
    if (Reset) begin
      chk("cmd_ready", 5'(cmd_ready), 5'(!m_busy));
      chk("busy", 5'(busy), 5'(m_busy));
      chk("rsp_valid", 5'(rsp_valid), 5'(m_rsp_valid));
      chk("rsp_data", rsp_data, m_rsp_data);
      chk("Operand_A", 5'(Operand_A), 5'(m_opa));
      chk("Operand_B", 5'(Operand_B), 5'(m_opb));
      chk("ALU_SEL", 5'(ALU_SEL), 5'(m_op));
      chk("Sel_A", 5'(Sel_A), 5'(m_sel_a));
      chk("Sel_B", 5'(Sel_B), 5'd1);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 5'(cmd_ready), 5'd1);
    chk({tag, "_busy"}, 5'(busy), 5'd0);
    chk({tag, "_rsp_valid"}, 5'(rsp_valid), 5'd0);
    chk({tag, "_rsp_data"}, rsp_data, 5'd0);
    chk({tag, "_Operand_A"}, 5'(Operand_A), 5'd0);
    chk({tag, "_Operand_B"}, 5'(Operand_B), 5'd0);
    chk({tag, "_Sel_A"}, 5'(Sel_A), 5'd1);
    chk({tag, "_Sel_B"}, 5'(Sel_B), 5'd1);
    chk({tag, "_ALU_SEL"}, 5'(ALU_SEL), 5'd0);
  endtask

  // Issue one command from IDLE (called at a negedge), hold the response
  // for 'hold' cycles, then complete it. Returns data, latency after the
  // accept edge, busy cycles and cycles with Sel_A=0.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain, input int hold, output logic [4:0] data,
                         output int lat, output int busy_n, output int sel0);
    int g;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    chk("accept_ready", 5'(cmd_ready), 5'd1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    lat = 0; busy_n = int'(busy); sel0 = int'(!Sel_A);
    while (!rsp_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++; busy_n += int'(busy); sel0 += int'(!Sel_A);
    end
    chk("rsp_timeout", 5'(rsp_valid), 5'd1);
    data = rsp_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'($urandom_range(0, 4)); cmd_a = 4'($urandom);
      @(posedge CLK); #1;
      busy_n += int'(busy); sel0 += int'(!Sel_A);
      chk("hold_rsp_valid", 5'(rsp_valid), 5'd1);
      chk("hold_rsp_data", rsp_data, data);
      chk("hold_cmd_ready", 5'(cmd_ready), 5'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    g = 0;
    do begin
      @(posedge CLK); #1;
      busy_n += int'(busy); sel0 += int'(!Sel_A); g++;
    end while (busy && g < 40);
    chk("idle_timeout", 5'(busy), 5'd0);
    rsp_ready = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [4:0] d;
    int lat, bn, s0;

    repeat (2) @(negedge CLK);
    chk_reset_vals("in_reset");
    Reset = 1'b1;
    @(negedge CLK);

    // ADD 9+8: latency 2+S, busy 4 cycles, 17 with carry in bit 4.
    run_cmd(ALU_OP_ADD, 4'd9, 4'd8, 1'b0, 0, d, lat, bn, s0);
    chk("add_lat", 5'(lat), 5'(2 + S));
    chk("add_busy", 5'(bn), 5'd4);
    chk("add_data", d, 5'd17);
    chk("add_model", m_rsp_data, 5'd17);

    // SUB 3-5: borrow shows in bit 4 (-2 -> 5'b11110).
    run_cmd(ALU_OP_SUB, 4'd3, 4'd5, 1'b0, 0, d, lat, bn, s0);
    chk("sub_data", d, 5'd30);
    chk("sub_sel0", 5'(s0), 5'd0);

    // Response stalled six cycles.
    run_cmd(ALU_OP_AND, 4'hC, 4'hA, 1'b0, 6, d, lat, bn, s0);
    chk("and_data", d, 5'd8);
    chk("stall_busy", 5'(bn), 5'd10);

    // Chaining: 9+8 then chained (a=4)+2.
    run_cmd(ALU_OP_ADD, 4'd9, 4'd8, 1'b0, 0, d, lat, bn, s0);
    chk("chain1_data", d, 5'd17);
    run_cmd(ALU_OP_ADD, 4'd4, 4'd2, 1'b1, 0, d, lat, bn, s0);
`ifdef ALU_SEQ_CHAIN_EN
    chk("chain2_data", d, 5'd3);
    chk("chain2_sel0", 5'(s0), 5'd1);
`else
    chk("chain2_data", d, 5'd6);
    chk("chain2_sel0", 5'(s0), 5'd0);
`endif

    // Reset mid-SETTLE: command dropped, outputs back to reset values.
    cmd_op = ALU_OP_ADD; cmd_a = 4'd7; cmd_b = 4'd7; cmd_chain = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #3;
    chk("pre_rst_busy", 5'(busy), 5'd1);
    Reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge CLK);
    Reset = 1'b1;
    rsp_ready = 1'b0;
    repeat (4) @(negedge CLK);
    // last_result cleared: a chained OR now uses 0 as A.
    run_cmd(ALU_OP_OR, 4'd8, 4'd5, 1'b1, 0, d, lat, bn, s0);
`ifdef ALU_SEQ_CHAIN_EN
    chk("post_rst_data", d, 5'd5);
`else
    chk("post_rst_data", d, 5'd13);
`endif

    // Random traffic checked every cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom_range(0, 4));
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_chain = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) @(negedge CLK);
    chk("drain_idle", 5'(busy), 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
